// File: rtl/display_pkg.sv
// display_pkg -- shared constants for the six-digit multiplexed clock display.
// Segment encodings are {a,b,c,d,e,f,g,dp}, active-high, with dp cleared.
package display_pkg;

    localparam int NUM_DIGITS = 6;

    // Digits that carry the colon separator on their dp segment.
    localparam logic [2:0] DP_DIGIT_A = 3'd2;
    localparam logic [2:0] DP_DIGIT_B = 3'd4;

    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hF6;
    localparam logic [7:0] SEG_DASH  = 8'h02;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    localparam logic [5:0] AN_OFF = 6'b111111;

endpackage

// File: rtl/display_scan_seg7_decode.sv
// seg7_decode -- combinational BCD to seven-segment decoder.
// Ports:
//   bcd  [3:0] in  : digit value; 10..15 render as a dash
//   segs [6:0] out : {a,b,c,d,e,f,g}, active-high
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] segs
);

    logic [7:0] pattern;

    always_comb begin
        pattern = SEG_DASH;
        case (bcd)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

    // The dp bit of the shared patterns is always zero; it is muxed in by the caller.
    assign segs = pattern[7:1];

endmodule

// File: rtl/display_scan.sv
// display_scan -- time-multiplexed driver for a six-digit HH:MM:SS display.
// Each digit slot lasts REFRESH_DIV clk cycles; the first cycle of a slot is
// a blank guard cycle against ghosting. All six digits are snapshotted at the
// end of each frame so a frame never mixes two times.
// Ports:
//   clk        in  : system clock, rising edge
//   rst        in  : asynchronous active-high reset
//   bcd1..bcd6 in  : sec units, sec tens, min units, min tens, hr units, hr tens
//   sec_pulse  in  : single-cycle 1 Hz strobe, toggles the colon dp
//   seg  [7:0] out : {a,b,c,d,e,f,g,dp}, active-high, registered
//   an   [5:0] out : one-hot active-low digit enables, registered
//   digit_idx  out : index 0..5 of the driven digit, registered
// Build option: define LEAD_ZERO_BLANK_EN to blank a leading zero on the
// hours-tens digit (its anode stays enabled).
module display_scan
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd2,
    input  logic [3:0] bcd3,
    input  logic [3:0] bcd4,
    input  logic [3:0] bcd5,
    input  logic [3:0] bcd6,
    input  logic       sec_pulse,
    output logic [7:0] seg,
    output logic [5:0] an,
    output logic [2:0] digit_idx
);

    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

    logic [PRE_W-1:0] pre;
    logic [2:0]       idx;
    logic [3:0]       snap [NUM_DIGITS];
    logic             dp_state;

    logic             tc;
    logic [3:0]       cur_digit;
    logic [6:0]       dec_segs;
    logic             dp_bit;
    logic [7:0]       seg_next;
    logic [5:0]       an_next;

    assign tc = (pre == PRE_LAST);

    always_comb begin
        cur_digit = 4'd0;
        case (idx)
            3'd0:    cur_digit = snap[0];
            3'd1:    cur_digit = snap[1];
            3'd2:    cur_digit = snap[2];
            3'd3:    cur_digit = snap[3];
            3'd4:    cur_digit = snap[4];
            3'd5:    cur_digit = snap[5];
            default: cur_digit = 4'd0;
        endcase
    end

    seg7_decode u_decode (
        .bcd  (cur_digit),
        .segs (dec_segs)
    );

    assign dp_bit = dp_state & ((idx == DP_DIGIT_A) || (idx == DP_DIGIT_B));

    always_comb begin
        seg_next = {dec_segs, dp_bit};
        an_next  = ~(6'b000001 << idx);
`ifdef LEAD_ZERO_BLANK_EN
        if ((idx == 3'd5) && (cur_digit == 4'd0)) begin
            seg_next = SEG_BLANK;
        end
`endif
        // Guard cycle wins over everything, including lead-zero blanking.
        if (pre == '0) begin
            seg_next = SEG_BLANK;
            an_next  = AN_OFF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre       <= '0;
            idx       <= 3'd0;
            dp_state  <= 1'b0;
            seg       <= SEG_BLANK;
            an        <= AN_OFF;
            digit_idx <= 3'd0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                snap[k] <= 4'd0;
            end
        end else begin
            pre <= tc ? '0 : pre + PRE_W'(1);
            if (tc) begin
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end
            if (tc && (idx == 3'd5)) begin
                snap[0] <= bcd1;
                snap[1] <= bcd2;
                snap[2] <= bcd3;
                snap[3] <= bcd4;
                snap[4] <= bcd5;
                snap[5] <= bcd6;
            end
            if (sec_pulse) begin
                dp_state <= ~dp_state;
            end
            seg       <= seg_next;
            an        <= an_next;
            digit_idx <= idx;
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan -- self-checking bench for display_scan (REFRESH_DIV = 4).
// A cycle-count based model predicts seg/an/digit_idx on every edge; directed
// literal checks pin the model, followed by a randomized phase.
module tb_display_scan;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] bcd_v [6];
    logic       sec_pulse = 1'b0;
    logic [7:0] seg;
    logic [5:0] an;
    logic [2:0] digit_idx;

    int checks = 0;
    int errors = 0;
    int ecnt   = -1;

    always #5 clk = ~clk;

    display_scan #(.REFRESH_DIV(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .bcd1      (bcd_v[0]),
        .bcd2      (bcd_v[1]),
        .bcd3      (bcd_v[2]),
        .bcd4      (bcd_v[3]),
        .bcd5      (bcd_v[4]),
        .bcd6      (bcd_v[5]),
        .sec_pulse (sec_pulse),
        .seg       (seg),
        .an        (an),
        .digit_idx (digit_idx)
    );

    // ---------------- behavioural model ----------------
    logic [7:0] lut [16];
    int         m_cyc;
    int         m_dp;
    int         m_snap [6];
    logic [7:0] exp_seg;
    logic [5:0] exp_an;
    logic [2:0] exp_idx;

    initial begin
        lut = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                8'hFE, 8'hF6, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02};
        for (int k = 0; k < 6; k++) begin
            bcd_v[k]  = 4'd0;
            m_snap[k] = 0;
        end
        m_cyc = 0;
        m_dp  = 0;
    end

    always @(posedge clk) begin
        int p;
        int i;
        if (rst) begin
            m_cyc = 0;
            m_dp  = 0;
            for (int k = 0; k < 6; k++) m_snap[k] = 0;
            exp_seg = 8'h00;
            exp_an  = 6'b111111;
            exp_idx = 3'd0;
        end else begin
            p = m_cyc % DIV;
            i = (m_cyc / DIV) % 6;
            exp_idx = 3'(i);
            if (p == 0) begin
                exp_seg = 8'h00;
                exp_an  = 6'b111111;
            end else begin
                exp_an  = ~(6'b000001 << i);
                exp_seg = lut[m_snap[i]];
                if ((i == 2 || i == 4) && m_dp == 1) exp_seg[0] = 1'b1;
`ifdef LEAD_ZERO_BLANK_EN
                if (i == 5 && m_snap[5] == 0) exp_seg = 8'h00;
`endif
            end
            if (sec_pulse) m_dp = 1 - m_dp;
            if (p == DIV - 1 && i == 5) begin
                for (int k = 0; k < 6; k++) m_snap[k] = int'(bcd_v[k]);
            end
            m_cyc++;
        end
        #1;
        checks++;
        if (seg !== exp_seg || an !== exp_an || digit_idx !== exp_idx) begin
            errors++;
            $display("FAIL model t=%0t: seg=%h an=%b idx=%0d, required seg=%h an=%b idx=%0d",
                     $time, seg, an, digit_idx, exp_seg, exp_an, exp_idx);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic goto(input int e);
        while (ecnt < e) begin
            @(posedge clk);
            ecnt++;
        end
        #1;
    endtask

    task automatic chk_lit(input string name, input logic [7:0] es,
                           input logic [5:0] ea, input logic [2:0] ei);
        checks++;
        if (seg !== es || an !== ea || digit_idx !== ei) begin
            errors++;
            $display("FAIL %s: seg=%h an=%b idx=%0d, required seg=%h an=%b idx=%0d",
                     name, seg, an, digit_idx, es, ea, ei);
        end
    endtask

    task automatic set_bcd(input int b1, input int b2, input int b3,
                           input int b4, input int b5, input int b6);
        bcd_v[0] = 4'(b1); bcd_v[1] = 4'(b2); bcd_v[2] = 4'(b3);
        bcd_v[3] = 4'(b4); bcd_v[4] = 4'(b5); bcd_v[5] = 4'(b6);
    endtask

    task automatic pulse_at(input int cyc);
        goto(cyc - 1);
        @(negedge clk) sec_pulse = 1'b1;
        goto(cyc);
        @(negedge clk) sec_pulse = 1'b0;
    endtask

    task automatic release_rst();
        @(negedge clk) rst = 1'b0;
        ecnt = -1;
    endtask

    logic [7:0] frame_segs [6];
    logic [7:0] lz_seg;

    initial begin
        frame_segs = '{8'hF6, 8'hB6, 8'hF6, 8'hB6, 8'hF2, 8'hDA};
`ifdef LEAD_ZERO_BLANK_EN
        lz_seg = 8'h00;
`else
        lz_seg = 8'hFC;
`endif
        repeat (3) @(posedge clk);
        #1 chk_lit("reset_hold", 8'h00, 6'b111111, 3'd0);
        release_rst();
        // hours 23, minutes 59, seconds 59
        set_bcd(9, 5, 9, 5, 3, 2);
        goto(0);  chk_lit("first_guard", 8'h00, 6'b111111, 3'd0);
        goto(1);  chk_lit("pre_capture_zero", 8'hFC, 6'b111110, 3'd0);
        goto(21); chk_lit("lead_zero_idx5", lz_seg, 6'b011111, 3'd5);
        goto(24); chk_lit("frame_guard", 8'h00, 6'b111111, 3'd0);
        for (int i = 0; i < 6; i++) begin
            goto(25 + 4 * i);
            chk_lit("frame_digit", frame_segs[i], ~(6'b000001 << i), 3'(i));
        end
        // mid-frame change during idx 3 of the frame spanning cycles 48..71
        goto(59);
        @(negedge clk) set_bcd(7, 1, 12, 1, 1, 1);
        goto(65); chk_lit("old_frame_idx4", 8'hF2, 6'b101111, 3'd4);
        goto(69); chk_lit("old_frame_idx5", 8'hDA, 6'b011111, 3'd5);
        goto(73); chk_lit("new_frame_idx0", 8'hE0, 6'b111110, 3'd0);
        pulse_at(74);
        goto(81); chk_lit("dash_dp_on", 8'h03, 6'b111011, 3'd2);
        goto(85); chk_lit("no_dp_idx3", 8'h60, 6'b110111, 3'd3);
        goto(89); chk_lit("dp_on_idx4", 8'h61, 6'b101111, 3'd4);
        pulse_at(91);   // coincides with terminal count of slot 4
        goto(93); chk_lit("tc_pulse_advance", 8'h60, 6'b011111, 3'd5);
        goto(105); chk_lit("dp_off_idx2", 8'h02, 6'b111011, 3'd2);
        pulse_at(106);
        goto(113); chk_lit("dp_on_again", 8'h61, 6'b101111, 3'd4);
        // reset during idx 4, pre 2
        goto(114);
        #2 rst = 1'b1;
        #1 chk_lit("async_reset", 8'h00, 6'b111111, 3'd0);
        repeat (2) @(posedge clk);
        release_rst();
        goto(0); chk_lit("restart_guard", 8'h00, 6'b111111, 3'd0);
        goto(1); chk_lit("restart_zero", 8'hFC, 6'b111110, 3'd0);

        // randomized phase
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            sec_pulse = ($urandom_range(5) == 0);
            if ($urandom_range(19) == 0) begin
                for (int k = 0; k < 6; k++) bcd_v[k] = 4'($urandom_range(15));
            end
            if (n == 1200) begin
                #2 rst = 1'b1;
                #1 chk_lit("random_async_reset", 8'h00, 6'b111111, 3'd0);
                @(negedge clk) rst = 1'b0;
            end
        end
        @(negedge clk) sec_pulse = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 1000, clk cycles per digit slot; legal range 2..65535.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 bcd1..bcd6  input  4 each  time digits: bcd1 = seconds units, bcd2 = seconds tens, bcd3 = minutes units, bcd4 = minutes tens, bcd5 = hours units, bcd6 = hours tens.
REQ-005 sec_pulse  input  1  single-cycle 1 Hz strobe in the clk domain.
REQ-006 seg  output  8  segment bus {a,b,c,d,e,f,g,dp}, active-high.
REQ-007 an  output  6  digit enables, one-hot active-low, an[k] drives the digit for bcd(k+1).
REQ-008 digit_idx  output  3  index of the digit currently driven, 0..5.

Function
REQ-009 Prescaler pre SHALL count 0..REFRESH_DIV-1, then wrap to 0; terminal count tc = (pre == REFRESH_DIV-1).
REQ-010 idx SHALL advance by 1 on tc and wrap 5->0; it SHALL hold otherwise.
REQ-011 On tc with idx==5, all six bcd inputs SHALL be captured into a snapshot; the display SHALL use only the snapshot, so one frame never mixes two times.
REQ-012 seg, an and digit_idx SHALL be registered: their values in cycle n+1 reflect pre, idx and snapshot in cycle n (1-cycle latency).
REQ-013 Guard cycle: when pre==0, an SHALL be 6'b111111 and seg 8'h00 (anti-ghosting); otherwise an = ~(6'b1 << idx).
REQ-014 Decode (hex, seg[7:0]): 0=FC 1=60 2=DA 3=F2 4=66 5=B6 6=BE 7=E0 8=FE 9=F6; snapshot values 10..15 SHALL show dash 02.
REQ-015 dp_state SHALL toggle on each sec_pulse; seg[0] SHALL equal dp_state when idx is 2 or 4 (colon separators); seg[0] SHALL be 0 on every other digit.
REQ-016 sec_pulse coincident with tc: both the toggle and the advance SHALL take effect in the same cycle.
REQ-017 sec_pulse during a guard cycle SHALL still toggle dp_state; the guard blanking overrides only the outputs.
REQ-018 digit_idx SHALL equal the registered idx and never exceed 5.

Reset
REQ-019 While rst is high: pre=0, idx=0, snapshot all 0, dp_state=0, seg=8'h00, an=6'b111111, digit_idx=0.
REQ-020 Reset mid-frame SHALL abort the frame immediately; after release, scanning SHALL restart at idx 0 showing snapshot zeros until the first capture.
REQ-021 The first clk edge after release SHALL be treated as pre==0 (guard cycle).

Configuration
REQ-022 Macro LEAD_ZERO_BLANK_EN: when defined, idx 5 with snapshot value 0 SHALL output seg=8'h00 with an still asserted; when undefined, it SHALL show FC as normal.

Structure
REQ-023 Shared package display_pkg SHALL hold the segment constants (digits 0..9, dash, blank), NUM_DIGITS=6 and the dp-digit indices 2 and 4.
REQ-024 Digit decoding SHALL be one combinational sub-module, seg7_decode (4-bit in, 7-bit a..g out, dash for 10..15); dp and blanking muxing stay in display_scan.

Verification
REQ-025 REFRESH_DIV=4, bcd6..1=2,3,5,9,5,9 held -> after the first capture, each frame drives an 111110,111101,...,011111 with segs F6,B6,F6,B6,F2,DA, plus a blank guard cycle at each slot start.
REQ-026 Change the bcd inputs mid-frame (idx=3) -> the current frame shows the old digits; the new digits appear only from the next idx 0.
REQ-027 sec_pulse three times -> dp toggles 1,0,1 on idx 2 and 4 only; a pulse on a tc cycle toggles once and the advance also occurs.
REQ-028 Assert rst at idx=4 with pre=2 -> outputs go 00 / 111111 / 0 asynchronously; after release, the scan restarts at idx 0 with segs FC.
REQ-029 bcd3=4'hC -> the idx 2 slot shows 02 (with dp per dp_state).
REQ-030 LEAD_ZERO_BLANK_EN defined, bcd6=0 -> idx 5 seg=00 with an=011111; undefined -> seg=FC.
